muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit; the consumer side of the ALU control decode.
- Takes funct3 (with funct7 = 0000001 already qualified upstream) plus two operands from the EX stage.
- Computes the result over multiple cycles and holds the pipeline via valid/ready handshakes.
- Sits beside the single-cycle ALU in EX; its result muxes into EX/MEM.

---
 rtl/muldiv_unit_pkg.sv | 13 +
 rtl/muldiv_unit_sign_fix.sv | 22 ++
 rtl/muldiv_unit.sv | 80 ++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: funct3 codes, FSM states and funct7 tag for the M-extension unit
package muldiv_unit_pkg;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// muldiv_sign_fix: sign correction of magnitude product/quotient/remainder and result select
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic              sa,
  input  logic              sb,
  input  logic              dz,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;
  always_comb begin
    prod = sa ^ sb ? -acc : acc;
    quo = dz ? '1 : sa ^ sb ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = op == F_MUL ? prod[XLEN-1:0] : !op[2] ? prod[2*XLEN-1:XLEN] : !op[1] ? quo : rem;
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit; MULDIV_EARLY_OUT_EN enables early-out for div-by-zero/overflow
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN-1:0] opb, a_mag, b_mag, fixed;
  logic [XLEN:0] sum, rr, diff;
  logic [2:0] op;
  logic sa, sb, dz, a_neg, b_neg, is_div, early, accept;
  assign is_div = funct3[2];
  assign a_neg = rs1_val[XLEN-1] & (funct3 inside {F_MULH, F_MULHSU, F_DIV, F_REM});
  assign b_neg = rs2_val[XLEN-1] & (funct3 inside {F_MULH, F_DIV, F_REM});
  assign a_mag = a_neg ? -rs1_val : rs1_val;
  assign b_mag = b_neg ? -rs2_val : rs2_val;
  assign accept = state == IDLE && in_valid && !flush;
`ifdef MULDIV_EARLY_OUT_EN
  assign early = is_div && (rs2_val == '0 || ((funct3 == F_DIV || funct3 == F_REM) &&
                 rs1_val == {1'b1, {(XLEN-1){1'b0}}} && rs2_val == '1));
`else
  assign early = 1'b0;
`endif
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign rr = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff = rr - {1'b0, opb};
  assign acc_nx = op[2] ? (diff[XLEN] ? {rr[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                        : {sum, acc[XLEN-1:1]};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (.op(op), .sa(sa), .sb(sb), .dz(dz), .acc(acc), .result(fixed));
  always_comb begin
    state_nx = flush ? IDLE : state == IDLE ? (in_valid ? CALC : IDLE) : state == CALC ? (cnt == '0 ? DONE : CALC)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      op <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op <= funct3;
      sa <= a_neg;
      sb <= b_neg;
      dz <= rs2_val == '0;
      opb <= is_div ? b_mag : a_mag;
      acc <= early && rs2_val == '0 ? {a_mag, {XLEN{1'b1}}} : {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
      cnt <= early ? '0 : CNT_W'(XLEN);
    end else if (state == CALC && !flush) begin
      if (cnt != '0) begin
        acc <= acc_nx;
        cnt <= cnt - 1'b1;
      end else result <= fixed;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench with an arithmetic reference model and result scoreboard
module tb_muldiv_unit;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] rs1_val = 0, rs2_val = 0, result;
  logic in_ready, out_valid, busy;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif
  muldiv_unit dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
                   .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush), .out_valid(out_valid),
                   .out_ready(out_ready), .result(result), .busy(busy));
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, b);
    longint sa, sb, ua, ub;
    logic [63:0] pss, psu, puu;
    logic dz, ovf;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    pss = sa * sb;
    psu = sa * ub;
    puu = ua * ub;
    dz = b == 0;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: return pss[31:0];
      3'd1: return pss[63:32];
      3'd2: return psu[63:32];
      3'd3: return puu[63:32];
      3'd4: return dz ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return dz ? 32'hFFFF_FFFF : a / b;
      3'd6: return dz ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return dz ? a : a % b;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid got %h want none", result);
      end else if (result !== exp_q[0]) begin
        errors++;
        $display("FAIL result got %h want %h", result, exp_q[0]);
      end
    end
  always @(posedge clk)
    if (!rst && !flush && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int lat, input int hold);
    int n;
    logic busy_ok, hold_ok;
    check("model", model(f, a, b), lit);
    check("in_ready_idle", {31'b0, in_ready}, 1);
    funct3 = f;
    rs1_val = a;
    rs2_val = b;
    in_valid = 1;
    exp_q.push_back(model(f, a, b));
    @(posedge clk);
    #1 in_valid = 0;
    n = 0;
    busy_ok = 1;
    while (!out_valid && n < 100) begin
      busy_ok &= busy & !in_ready;
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, lat);
    check("busy_calc", {31'b0, busy_ok}, 1);
    hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      @(posedge clk);
      #1 hold_ok &= out_valid & !in_ready & busy;
    end
    in_valid = 0;
    if (hold > 0) check("hold", {31'b0, hold_ok}, 1);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("out_valid_drop", {31'b0, out_valid}, 0);
    check("in_ready_back", {31'b0, in_ready}, 1);
  endtask
  task automatic abort_op(input logic use_rst);
    int seen;
    funct3 = 3'd4;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) rst = 1;
    else flush = 1;
    @(posedge clk);
    #1 rst = 0;
    flush = 0;
    check(use_rst ? "rst_in_ready" : "flush_in_ready", {31'b0, in_ready}, 1);
    check(use_rst ? "rst_busy" : "flush_busy", {31'b0, busy}, 0);
    check(use_rst ? "rst_out_valid" : "flush_out_valid", {31'b0, out_valid}, 0);
    if (use_rst) check("rst_result", result, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 seen += int'(out_valid);
    end
    check(use_rst ? "rst_no_result" : "flush_no_result", seen, 0);
  endtask
  initial begin
    #1 rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    check("reset_in_ready", {31'b0, in_ready}, 1);
    check("reset_out_valid", {31'b0, out_valid}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_result", result, 0);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, EL, 0);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, EL, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, EL, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, EL, 0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, EL, 0);
    run_op(3'd7, 32'd5, 32'd0, 32'd5, EL, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EL, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, EL, 0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    run_op(3'd0, 32'd6, 32'd9, 32'd54, 33, 5);
    run_op(3'd5, 32'd81, 32'd9, 32'd9, 33, 0);
    abort_op(1'b0);
    run_op(3'd7, 32'd1000, 32'd3, 32'd1, 33, 0);
    abort_op(1'b1);
    run_op(3'd4, 32'd1000, 32'd3, 32'd333, 33, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
